enc_layer_sequencer: RTL

- Controller that sequences a BATCH-lane dense-layer MAC datapath (Q4.11, y = W·x + b) across all OUT_SIZE neurons, one lane group at a time.
- Sits between the arrhythmia-detector top-level FSM and the shared encoder datapath.
- Issues bias-load, MAC, store and lane-mask controls plus weight/output indices.
- Reports busy/done for the layer; the datapath and memories stay outside this block.

---
 rtl/enc_layer_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/enc_layer_sequencer.sv
// Sequences a BATCH-lane dense-layer MAC datapath over all OUT_SIZE neurons,
// one lane group at a time: bias load, IN_SIZE MAC steps, store.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// BIAS  | preload accumulators of current group with bias
// MAC   | accumulate x[in_idx]*w, in_idx = 0..IN_SIZE-1
// STORE | write accumulators of current group to y
// DONE  | one-cycle done pulse, then back to IDLE
module enc_layer_sequencer #(
    parameter int IN_SIZE  = 4,
    parameter int OUT_SIZE = 92,
    parameter int BATCH    = 32,
    localparam int NGRP    = (OUT_SIZE + BATCH - 1) / BATCH,
    localparam int IDX_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
    localparam int GRP_W   = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int OB_W    = $clog2(OUT_SIZE) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             bias_en,
    output logic             acc_en,
    output logic             store_en,
    output logic [IDX_W-1:0] in_idx,
    output logic [GRP_W-1:0] grp_idx,
    output logic [OB_W-1:0]  out_base,
    output logic [BATCH-1:0] lane_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t state;

    function automatic logic [BATCH-1:0] mask_for(input int g);
        logic [BATCH-1:0] m;
        m = '0;
        for (int l = 0; l < BATCH; l++) begin
            if (g * BATCH + l < OUT_SIZE) m[l] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [OB_W-1:0] base_for(input int g);
        return OB_W'(g * BATCH);
    endfunction

    // A raised strobe means the current step completed this cycle; a low strobe
    // while in an active state means the step is still pending (stalled).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bias_en   <= 1'b0;
            acc_en    <= 1'b0;
            store_en  <= 1'b0;
            in_idx    <= '0;
            grp_idx   <= '0;
            out_base  <= '0;
            lane_mask <= '0;
        end else begin
            bias_en  <= 1'b0;
            acc_en   <= 1'b0;
            store_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_BIAS;
                        busy      <= 1'b1;
                        in_idx    <= '0;
                        grp_idx   <= '0;
                        out_base  <= base_for(0);
                        lane_mask <= mask_for(0);
                        bias_en   <= !stall;
                    end
                end
                S_BIAS: begin
                    if (bias_en) begin
                        state  <= S_MAC;
                        in_idx <= '0;
                        acc_en <= !stall;
                    end else begin
                        bias_en <= !stall;
                    end
                end
                S_MAC: begin
                    if (acc_en) begin
                        if (in_idx == IDX_W'(IN_SIZE - 1)) begin
                            state    <= S_STORE;
                            store_en <= !stall;
                        end else begin
                            in_idx <= in_idx + IDX_W'(1);
                            acc_en <= !stall;
                        end
                    end else begin
                        acc_en <= !stall;
                    end
                end
                S_STORE: begin
                    if (store_en) begin
                        if (grp_idx == GRP_W'(NGRP - 1)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            in_idx    <= '0;
                            grp_idx   <= '0;
                            out_base  <= '0;
                            lane_mask <= '0;
                        end else begin
                            state     <= S_BIAS;
                            in_idx    <= '0;
                            grp_idx   <= grp_idx + GRP_W'(1);
                            out_base  <= base_for(int'(grp_idx) + 1);
                            lane_mask <= mask_for(int'(grp_idx) + 1);
                            bias_en   <= !stall;
                        end
                    end else begin
                        store_en <= !stall;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
